// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack controller with lane alignment,
// byte enables, load extension, misalignment and timeout errors.
module mem_access_stage #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSign,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MEM_Flush,
  output logic [31:0] MemData_o,
  output logic        MEM_Stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic          sign_q;
  logic          load_q;
  logic          flush_q;
  logic [31:0]   data_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        start;
  logic        timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  function automatic logic [31:0] align(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic        sg
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {ln, 3'b000});
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   align = {{24{sg & b[7]}}, b};
      2'b01:   align = {{16{sg & h[15]}}, h};
      default: align = w;
    endcase
  endfunction

  assign access  = (MemRead | MemWrite) & ~MEM_Flush;
  assign is_byte = (MemSize == 2'b00);
  assign is_half = (MemSize == 2'b01);
  assign is_word = MemSize[1];

  assign misaligned = (is_half & Addr[0]) |
                      (is_word & (Addr[1:0] != 2'b00));
  assign start = (state == IDLE) & access & ~misaligned;

  assign cnt_n   = cnt + 1'b1;
  assign timeout = ~dmem_ack & (cnt_n == CW'(WAIT_LIMIT));

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = WriteData;
    unique case (1'b1)
      is_byte: begin
        be_n    = 4'b0001 << Addr[1:0];
        wdata_n = {4{WriteData[7:0]}};
      end
      is_half: begin
        be_n    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{WriteData[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = WriteData;
      end
    endcase
    if (MemRead) be_n = 4'b1111;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = REQ;
      REQ:     if (dmem_ack | timeout) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign MEM_Stall = ~rst & (start | (state == REQ));
  assign MemData_o = (state == DONE && !flush_q) ? data_q : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      size_q     <= 2'd0;
      lane_q     <= 2'd0;
      sign_q     <= 1'b0;
      load_q     <= 1'b0;
      flush_q    <= 1'b0;
      data_q     <= 32'd0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state    <= state_n;
      addr_err <= (state == IDLE) & access & misaligned;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dmem_req   <= 1'b1;
          dmem_we    <= ~MemRead;
          dmem_addr  <= {Addr[31:2], 2'b00};
          dmem_be    <= be_n;
          dmem_wdata <= wdata_n;
          size_q     <= MemSize;
          lane_q     <= Addr[1:0];
          sign_q     <= MemSign;
          load_q     <= MemRead;
          cnt        <= '0;
          flush_q    <= 1'b0;
          data_q     <= 32'd0;
        end
        REQ: begin
          cnt <= cnt_n;
          if (MEM_Flush) flush_q <= 1'b1;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            data_q   <= load_q ?
              align(dmem_rdata, size_q, lane_q, sign_q) : 32'd0;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            data_q   <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, alignment,
// timeout, flush and reset during a pending request.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSign;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MEM_Flush;
  logic [31:0] MemData_o;
  logic        MEM_Stall;
  logic        addr_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int checks = 0;
  int fails  = 0;

  mem_access_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemSign(MemSign),
    .Addr(Addr), .WriteData(WriteData),
    .MEM_Flush(MEM_Flush),
    .MemData_o(MemData_o), .MEM_Stall(MEM_Stall),
    .addr_err(addr_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic clr();
    MemRead = 0; MemWrite = 0; MemSize = 0; MemSign = 0;
    Addr = 0; WriteData = 0; MEM_Flush = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic drv(input logic rd, input logic wr,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSign = sg;
    Addr = a; WriteData = wd;
  endtask

  task automatic test_reset();
    rst = 1;
    clr();
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (MEM_Stall !== 1'b0) begin
      fails++; $display("FAIL rst_stall got=%b exp=0", MEM_Stall);
    end
    checks++;
    if ({dmem_req, dmem_we, dmem_be, addr_err, bus_err} !== 8'd0) begin
      fails++; $display("FAIL rst_ctl got=%b exp=0",
        {dmem_req, dmem_we, dmem_be, addr_err, bus_err});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, MemData_o} !== 96'd0) begin
      fails++; $display("FAIL rst_data got=%h exp=0",
        {dmem_addr, dmem_wdata, MemData_o});
    end
    clr();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_lw();
    @(negedge clk);
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    #1;
    checks++;
    if (MEM_Stall !== 1'b1 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL lw_c0 stall=%b req=%b exp 1 0",
        MEM_Stall, dmem_req);
    end
    @(negedge clk);
    checks++;
    if ({dmem_req, MEM_Stall, dmem_we, dmem_be} !== 7'b1101111) begin
      fails++; $display("FAIL lw_req got=%b exp=1101111",
        {dmem_req, MEM_Stall, dmem_we, dmem_be});
    end
    checks++;
    if (dmem_addr !== 32'h100) begin
      fails++; $display("FAIL lw_addr got=%h exp=100", dmem_addr);
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    dmem_ack = 0;
    checks++;
    if (MEM_Stall !== 1'b0 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL lw_done stall=%b req=%b exp 0 0",
        MEM_Stall, dmem_req);
    end
    checks++;
    if (MemData_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL lw_data got=%h exp=deadbeef", MemData_o);
    end
    clr();
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        sg [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                            32'h0000FF7F, 32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv(1, 0, sz[i], sg[i], ad[i], 0);
      @(negedge clk);
      dmem_ack = 1; dmem_rdata = 32'h80FFFF7F;
      @(negedge clk);
      dmem_ack = 0;
      checks++;
      if (MemData_o !== ex[i]) begin
        fails++; $display("FAIL load_ext[%0d] got=%h exp=%h",
          i, MemData_o, ex[i]);
      end
      clr();
    end
  endtask

  task automatic test_store();
    logic [1:0]  sz [3] = '{2'b01, 2'b00, 2'b10};
    logic [31:0] ad [3] = '{32'h202, 32'h201, 32'h300};
    logic [31:0] wd [3] = '{32'h1234ABCD, 32'h00000077, 32'hCAFEF00D};
    logic [3:0]  eb [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew [3] = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
    logic [31:0] ea [3] = '{32'h200, 32'h200, 32'h300};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(0, 1, sz[i], 0, ad[i], wd[i]);
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_we, dmem_be} !== {2'b11, eb[i]}) begin
        fails++; $display("FAIL st_ctl[%0d] got=%b exp=%b",
          i, {dmem_req, dmem_we, dmem_be}, {2'b11, eb[i]});
      end
      checks++;
      if (dmem_wdata !== ew[i] || dmem_addr !== ea[i]) begin
        fails++; $display("FAIL st_data[%0d] got=%h/%h exp=%h/%h",
          i, dmem_wdata, dmem_addr, ew[i], ea[i]);
      end
      dmem_ack = 1; dmem_rdata = 32'h55555555;
      @(negedge clk);
      dmem_ack = 0;
      checks++;
      if (MemData_o !== 32'd0 || MEM_Stall !== 1'b0) begin
        fails++; $display("FAIL st_done[%0d] data=%h stall=%b exp 0 0",
          i, MemData_o, MEM_Stall);
      end
      clr();
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [2] = '{2'b10, 2'b01};
    logic [31:0] ad [2] = '{32'h101, 32'h103};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drv(1, 0, sz[i], 0, ad[i], 0);
      #1;
      checks++;
      if (MEM_Stall !== 1'b0) begin
        fails++; $display("FAIL mis_stall[%0d] got=%b exp=0",
          i, MEM_Stall);
      end
      @(negedge clk);
      clr();
      checks++;
      if ({addr_err, dmem_req, MEM_Stall} !== 3'b100 ||
          MemData_o !== 32'd0) begin
        fails++; $display("FAIL mis_err[%0d] got=%b data=%h exp=100 0",
          i, {addr_err, dmem_req, MEM_Stall}, MemData_o);
      end
      @(negedge clk);
      checks++;
      if (addr_err !== 1'b0) begin
        fails++; $display("FAIL mis_pulse[%0d] got=%b exp=0",
          i, addr_err);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    dmem_rdata = 32'h12345678;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1) break;
      n++;
    end
    clr();
    checks++;
    if (n !== 4) begin
      fails++; $display("FAIL to_len got=%0d exp=4", n);
    end
    checks++;
    if ({bus_err, MEM_Stall} !== 2'b10 || MemData_o !== 32'd0) begin
      fails++; $display("FAIL to_done got=%b data=%h exp=10 0",
        {bus_err, MEM_Stall}, MemData_o);
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      fails++; $display("FAIL to_pulse got=%b exp=0", bus_err);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    MEM_Flush = 1;
    dmem_ack = 1;
    #1;
    checks++;
    if (MEM_Stall !== 1'b0) begin
      fails++; $display("FAIL fl_idle_stall got=%b exp=0", MEM_Stall);
    end
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || addr_err !== 1'b0) begin
      fails++; $display("FAIL fl_idle_req got=%b%b exp=00",
        dmem_req, addr_err);
    end
    clr();
    @(negedge clk);
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    @(negedge clk);
    MEM_Flush = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      MEM_Flush = 0;
      checks++;
      if (dmem_req !== 1'b1 || MEM_Stall !== 1'b1) begin
        fails++; $display("FAIL fl_hold[%0d] req=%b stall=%b exp 1 1",
          k, dmem_req, MEM_Stall);
      end
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    clr();
    checks++;
    if ({dmem_req, MEM_Stall} !== 2'b00 || MemData_o !== 32'd0) begin
      fails++; $display("FAIL fl_done got=%b data=%h exp=00 0",
        {dmem_req, MEM_Stall}, MemData_o);
    end
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    drv(0, 1, 2'b10, 0, 32'h400, 32'h0BADF00D);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({dmem_req, MEM_Stall, dmem_we, dmem_be} !== 7'd0 ||
        dmem_addr !== 32'd0 || dmem_wdata !== 32'd0) begin
      fails++; $display("FAIL rst_req got=%b %h %h exp=0",
        {dmem_req, MEM_Stall, dmem_we, dmem_be}, dmem_addr, dmem_wdata);
    end
    clr();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drv(1, 0, 2'b10, 0, 32'h100, 0);
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'h11112222;
    @(negedge clk);
    dmem_ack = 0;
    checks++;
    if (MemData_o !== 32'h11112222) begin
      fails++; $display("FAIL b2b_a got=%h exp=11112222", MemData_o);
    end
    drv(1, 0, 2'b01, 1, 32'h106, 0);
    @(negedge clk);
    checks++;
    if (MEM_Stall !== 1'b1 || dmem_req !== 1'b0) begin
      fails++; $display("FAIL b2b_idle stall=%b req=%b exp 1 0",
        MEM_Stall, dmem_req);
    end
    @(negedge clk);
    checks++;
    if (dmem_addr !== 32'h104 || dmem_req !== 1'b1) begin
      fails++; $display("FAIL b2b_req addr=%h req=%b exp 104 1",
        dmem_addr, dmem_req);
    end
    dmem_ack = 1; dmem_rdata = 32'h9ABC0000;
    @(negedge clk);
    clr();
    checks++;
    if (MemData_o !== 32'hFFFF9ABC) begin
      fails++; $display("FAIL b2b_b got=%h exp=ffff9abc", MemData_o);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_flush();
    test_reset_in_req();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
